// File: rtl/pad_alsaqr_pkg.sv
// Shared types for the pad_alsaqr bank power sequencer: FSM state encoding,
// safe pad values, and the per-pad control bundle.
package pad_alsaqr_pkg;

  // 3-bit encoding is exported unchanged on state_o for debug.
  typedef enum logic [2:0] {
    OFF       = 3'd0,
    IO_UP     = 3'd1,
    CORE_UP   = 3'd2,
    ACTIVE    = 3'd3,
    RET_ENTER = 3'd4,
    RETENTION = 3'd5,
    RET_EXIT  = 3'd6,
    PWR_DOWN  = 3'd7
  } pwr_state_e;

  // How the pad control registers update on the next edge.
  typedef enum logic [1:0] {
    PAD_HOLD = 2'd0,
    PAD_SAFE = 2'd1,
    PAD_CORE = 2'd2
  } pad_mode_e;

  localparam logic SAFE_OEN = 1'b1;  // output driver disabled
  localparam logic SAFE_I   = 1'b0;

  typedef struct packed {
    logic oen;
    logic i;
    logic puen;
  } pad_ctrl_t;

  function automatic pad_ctrl_t safe_pad(input logic puen);
    pad_ctrl_t p;
    p.oen  = SAFE_OEN;
    p.i    = SAFE_I;
    p.puen = puen;
    return p;
  endfunction

endpackage

// File: rtl/pad_alsaqr_pwr_seq_if.sv
// Bundle of the core-side requests/pad-mux inputs and the pad-ring outputs
// of one pad bank. master = core/ring side, slave = the sequencer.
interface pad_alsaqr_pwr_seq_if #(
  parameter int NUM_PADS = 32
);
  logic                pwr_en_i;
  logic                ret_req_i;
  logic [NUM_PADS-1:0] core_oen_i;
  logic [NUM_PADS-1:0] core_i_i;
  logic [NUM_PADS-1:0] core_puen_i;
  logic [NUM_PADS-1:0] pad_oen_o;
  logic [NUM_PADS-1:0] pad_i_o;
  logic [NUM_PADS-1:0] pad_puen_o;
  logic                iopwrok_o;
  logic                pwrok_o;
  logic                retc_o;
  logic                ready_o;
  logic                ret_ack_o;
  logic [2:0]          state_o;

  modport master (
    output pwr_en_i, ret_req_i, core_oen_i, core_i_i, core_puen_i,
    input  pad_oen_o, pad_i_o, pad_puen_o, iopwrok_o, pwrok_o, retc_o,
           ready_o, ret_ack_o, state_o
  );

  modport slave (
    input  pwr_en_i, ret_req_i, core_oen_i, core_i_i, core_puen_i,
    output pad_oen_o, pad_i_o, pad_puen_o, iopwrok_o, pwrok_o, retc_o,
           ready_o, ret_ack_o, state_o
  );
endinterface

// File: rtl/pad_seq_timer.sv
// Down-counter for the timed sequencer states. A load sets the count to
// T-1; the count then decrements to 0 and stays there, so a state that
// leaves when zero is seen lasts exactly T cycles.
module pad_seq_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_reg;

  // Load has priority over the saturating decrement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               cnt_reg <= '0;
    else if (load)             cnt_reg <= load_val;
    else if (cnt_reg != '0)    cnt_reg <= cnt_reg - W'(1);
  end

  assign zero = (cnt_reg == '0);
endmodule

// File: rtl/pad_alsaqr_pwr_seq.sv
// Power-up / power-down / retention sequencer for one bank of pad_alsaqr
// cells. Drives the bank rails and gates the core pad-mux outputs so the
// pads only follow the core while the bank is ACTIVE.
module pad_alsaqr_pwr_seq
  import pad_alsaqr_pkg::*;
#(
  parameter int   NUM_PADS   = 32,
  parameter int   T_IO_CYC   = 16,
  parameter int   T_CORE_CYC = 16,
  parameter int   T_RET_CYC  = 8,
  parameter logic SAFE_PUEN  = 1'b0
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  pad_alsaqr_pwr_seq_if.slave bus
);
  localparam int T_MAX_IC = (T_IO_CYC > T_CORE_CYC) ? T_IO_CYC : T_CORE_CYC;
  localparam int T_MAX    = (T_MAX_IC > T_RET_CYC) ? T_MAX_IC : T_RET_CYC;
  localparam int CW       = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] LD_IO   = CW'(T_IO_CYC - 1);
  localparam logic [CW-1:0] LD_CORE = CW'(T_CORE_CYC - 1);
  localparam logic [CW-1:0] LD_RET  = CW'(T_RET_CYC - 1);

  pwr_state_e    state_reg, state_next;
  logic          iopwrok_reg, iopwrok_next;
  logic          pwrok_reg, pwrok_next;
  logic          retc_reg, retc_next;
  logic          ready_reg, ready_next;
  logic          ret_ack_reg, ret_ack_next;
  pad_mode_e     pad_mode;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;
  logic          go_down;

  pad_seq_timer #(.W(CW)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Losing pwr_en aborts every powered state except an ongoing power-down.
  assign go_down = !bus.pwr_en_i && (state_reg != OFF) && (state_reg != PWR_DOWN);

  // State and rail registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= OFF;
      iopwrok_reg <= 1'b0;
      pwrok_reg   <= 1'b0;
      retc_reg    <= 1'b0;
      ready_reg   <= 1'b0;
      ret_ack_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      iopwrok_reg <= iopwrok_next;
      pwrok_reg   <= pwrok_next;
      retc_reg    <= retc_next;
      ready_reg   <= ready_next;
      ret_ack_reg <= ret_ack_next;
    end
  end

  // Next state, next rail values, pad update mode and timer reloads.
  always_comb begin
    state_next   = state_reg;
    iopwrok_next = iopwrok_reg;
    pwrok_next   = pwrok_reg;
    retc_next    = retc_reg;
    ready_next   = ready_reg;
    ret_ack_next = ret_ack_reg;
    pad_mode     = PAD_HOLD;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    case (state_reg)
      OFF: begin
        pad_mode = PAD_SAFE;
        if (bus.pwr_en_i) begin
          state_next   = IO_UP;
          iopwrok_next = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = LD_IO;
        end
      end
      IO_UP: begin
        pad_mode = PAD_SAFE;
        if (tmr_zero) begin
          state_next = CORE_UP;
          pwrok_next = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = LD_CORE;
        end
      end
      CORE_UP: begin
        pad_mode = PAD_SAFE;
        if (tmr_zero) begin
          state_next = ACTIVE;
          ready_next = 1'b1;
        end
      end
      ACTIVE: begin
        // The edge leaving ACTIVE for retention still captures the core
        // values; those are what the pads hold while frozen.
        pad_mode = PAD_CORE;
        if (bus.ret_req_i) begin
          state_next = RET_ENTER;
          retc_next  = 1'b1;
          ready_next = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = LD_RET;
        end
      end
      RET_ENTER: begin
        if (tmr_zero) begin
          state_next   = RETENTION;
          ret_ack_next = 1'b1;
          pwrok_next   = 1'b0;
        end
      end
      RETENTION: begin
        if (!bus.ret_req_i) begin
          state_next   = RET_EXIT;
          ret_ack_next = 1'b0;
          pwrok_next   = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = LD_CORE;
        end
      end
      RET_EXIT: begin
        if (tmr_zero) begin
          state_next = ACTIVE;
          retc_next  = 1'b0;
          ready_next = 1'b1;
        end
      end
      PWR_DOWN: begin
        pad_mode = PAD_SAFE;
        if (tmr_zero) begin
          state_next   = OFF;
          iopwrok_next = 1'b0;
        end
      end
      default: begin
        state_next = OFF;
        pad_mode   = PAD_SAFE;
      end
    endcase

    // Power removal overrides whatever the state above decided.
    if (go_down) begin
      state_next   = PWR_DOWN;
      pwrok_next   = 1'b0;
      retc_next    = 1'b0;
      ready_next   = 1'b0;
      ret_ack_next = 1'b0;
      pad_mode     = PAD_SAFE;
      tmr_load     = 1'b1;
      tmr_val      = LD_CORE;
    end
  end

  // One control register per pad: forced safe, frozen, or tracking the core.
  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    pad_ctrl_t pad_reg;

    // Pad control update selected by the sequencer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pad_reg <= safe_pad(SAFE_PUEN);
      end else begin
        case (pad_mode)
          PAD_SAFE: pad_reg <= safe_pad(SAFE_PUEN);
          PAD_CORE: begin
            pad_reg.oen  <= bus.core_oen_i[gi];
            pad_reg.i    <= bus.core_i_i[gi];
            pad_reg.puen <= bus.core_puen_i[gi];
          end
          default:  pad_reg <= pad_reg;
        endcase
      end
    end

    assign bus.pad_oen_o[gi]  = pad_reg.oen;
    assign bus.pad_i_o[gi]    = pad_reg.i;
    assign bus.pad_puen_o[gi] = pad_reg.puen;
  end

  assign bus.iopwrok_o = iopwrok_reg;
  assign bus.pwrok_o   = pwrok_reg;
  assign bus.retc_o    = retc_reg;
  assign bus.ready_o   = ready_reg;
  assign bus.ret_ack_o = ret_ack_reg;
  assign bus.state_o   = state_reg;
endmodule

// File: tb/tb_pad_alsaqr_pwr_seq.sv
// Directed bench for pad_alsaqr_pwr_seq with default timing
// (T_IO=16, T_CORE=16, T_RET=8, SAFE_PUEN=0). Inputs change 1 time unit
// after the rising edge; outputs are checked at the same point.
module tb_pad_alsaqr_pwr_seq;
  import pad_alsaqr_pkg::*;

  localparam int NP = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  pad_alsaqr_pwr_seq_if #(.NUM_PADS(NP)) bus ();

  pad_alsaqr_pwr_seq #(
    .NUM_PADS   (NP),
    .T_IO_CYC   (16),
    .T_CORE_CYC (16),
    .T_RET_CYC  (8),
    .SAFE_PUEN  (1'b0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_safe(input string tag);
    chk({tag, "_oen"},  bus.pad_oen_o,  32'hFFFF_FFFF);
    chk({tag, "_i"},    bus.pad_i_o,    32'h0);
    chk({tag, "_puen"}, bus.pad_puen_o, 32'h0);
  endtask

  task automatic chk_rails(input string tag, input logic iop, input logic pok,
                           input logic retc, input logic rdy, input logic ack,
                           input logic [2:0] st);
    chk({tag, "_iopwrok"}, 32'(bus.iopwrok_o), 32'(iop));
    chk({tag, "_pwrok"},   32'(bus.pwrok_o),   32'(pok));
    chk({tag, "_retc"},    32'(bus.retc_o),    32'(retc));
    chk({tag, "_ready"},   32'(bus.ready_o),   32'(rdy));
    chk({tag, "_ret_ack"}, 32'(bus.ret_ack_o), 32'(ack));
    chk({tag, "_state"},   32'(bus.state_o),   32'(st));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (bus.state_o !== st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.state_o), 32'(st));
  endtask

  initial begin
    rst_n           = 1'b1;
    bus.pwr_en_i    = 1'b0;
    bus.ret_req_i   = 1'b0;
    bus.core_oen_i  = '0;
    bus.core_i_i    = '0;
    bus.core_puen_i = '0;
    #1 rst_n = 1'b0;
    #2;
    chk_rails("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OFF);
    chk_safe("rst");
    $display("reset: outputs checked before first clock");

    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_rails("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OFF);

    // Power-up: pwr_en at cycle 0 -> iopwrok@1, pwrok@17, ready@33, pads@34.
    bus.core_i_i    = 32'hA5A5_A5A5;
    bus.core_oen_i  = 32'h0000_0000;
    bus.core_puen_i = 32'h0F0F_0F0F;
    bus.pwr_en_i    = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      tick();
      chk("up_iopwrok", 32'(bus.iopwrok_o), 32'(1));
      chk("up_pwrok",   32'(bus.pwrok_o),   32'(c >= 17));
      chk("up_ready",   32'(bus.ready_o),   32'(c >= 33));
      chk("up_retc",    32'(bus.retc_o),    32'(0));
      if (c <= 33) begin
        chk_safe("up_pad");
      end else begin
        chk("up_pad_i",    bus.pad_i_o,    32'hA5A5_A5A5);
        chk("up_pad_oen",  bus.pad_oen_o,  32'h0000_0000);
        chk("up_pad_puen", bus.pad_puen_o, 32'h0F0F_0F0F);
      end
    end
    chk("up_state", 32'(bus.state_o), 32'(ACTIVE));
    $display("power-up: rails at 1/17/33, pads track core from 34");

    // Retention entry: retc next cycle, ret_ack/pwrok-drop 8 cycles later.
    bus.core_i_i  = 32'h1234_5678;
    bus.ret_req_i = 1'b1;
    tick();
    chk_rails("ren1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, RET_ENTER);
    chk("ren1_pad_i", bus.pad_i_o, 32'h1234_5678);
    bus.core_i_i = 32'hFFFF_FFFF;
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk("ren_ret_ack", 32'(bus.ret_ack_o), 32'(c == 9));
      chk("ren_pwrok",   32'(bus.pwrok_o),   32'(c < 9));
      chk("ren_retc",    32'(bus.retc_o),    32'(1));
      chk("ren_iopwrok", 32'(bus.iopwrok_o), 32'(1));
      chk("ren_pad_i",   bus.pad_i_o,        32'h1234_5678);
    end
    chk("ren_state", 32'(bus.state_o), 32'(RETENTION));
    $display("retention entry: ret_ack after 8 cycles, pads frozen");

    // Retention exit: pwrok next cycle, ready 16 later, pads resume after.
    bus.ret_req_i = 1'b0;
    tick();
    chk_rails("rex1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, RET_EXIT);
    for (int c = 2; c <= 18; c++) begin
      tick();
      chk("rex_ready", 32'(bus.ready_o), 32'(c >= 17));
      chk("rex_retc",  32'(bus.retc_o),  32'(c < 17));
      chk("rex_pad_i", bus.pad_i_o, (c >= 18) ? 32'hFFFF_FFFF : 32'h1234_5678);
    end
    chk("rex_state", 32'(bus.state_o), 32'(ACTIVE));
    $display("retention exit: ready after 16 cycles, tracking resumes");

    // pwr_en drop and ret_req in the same ACTIVE cycle: power-down wins.
    bus.pwr_en_i  = 1'b0;
    bus.ret_req_i = 1'b1;
    tick();
    chk_rails("pd1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PWR_DOWN);
    chk_safe("pd1_pad");
    for (int c = 2; c <= 17; c++) begin
      tick();
      chk("pd_retc",    32'(bus.retc_o),    32'(0));
      chk("pd_iopwrok", 32'(bus.iopwrok_o), 32'(c < 17));
    end
    chk("pd_state", 32'(bus.state_o), 32'(OFF));
    bus.ret_req_i = 1'b0;
    $display("power-down priority: retc never rose, OFF after 16 cycles");

    // Abort during CORE_UP, 5 cycles after pwrok rise; toggle ignored in PWR_DOWN.
    bus.pwr_en_i = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      chk("ab_pwrok", 32'(bus.pwrok_o), 32'(c >= 17));
    end
    bus.pwr_en_i = 1'b0;
    for (int c = 23; c <= 39; c++) begin
      tick();
      chk("ab_pwrok",   32'(bus.pwrok_o),   32'(0));
      chk("ab_iopwrok", 32'(bus.iopwrok_o), 32'(c < 39));
      chk("ab_state",   32'(bus.state_o),   (c < 39) ? 32'(PWR_DOWN) : 32'(OFF));
      if (c == 23) chk_safe("ab_pad");
      if (c == 25) bus.pwr_en_i = 1'b1;
    end
    tick();
    chk_rails("ab40", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IO_UP);
    $display("core-up abort: PWR_DOWN next cycle, OFF 16 later, restart from OFF");

    // Asynchronous reset in the middle of RET_EXIT, then a clean restart.
    wait_state("rst_to_active", ACTIVE, 64);
    bus.ret_req_i = 1'b1;
    wait_state("rst_to_ret", RETENTION, 32);
    bus.ret_req_i = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_pre_state", 32'(bus.state_o), 32'(RET_EXIT));
    #3 rst_n = 1'b0;
    #1;
    chk_rails("arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OFF);
    chk_safe("arst_pad");
    rst_n = 1'b1;
    tick();
    chk_rails("rs1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IO_UP);
    for (int c = 2; c <= 34; c++) begin
      tick();
      chk("rs_pwrok", 32'(bus.pwrok_o), 32'(c >= 17));
      chk("rs_ready", 32'(bus.ready_o), 32'(c >= 33));
      chk("rs_pad_i", bus.pad_i_o, (c >= 34) ? 32'hFFFF_FFFF : 32'h0);
    end
    $display("async reset mid RET_EXIT: reset values, resequence normal");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pad_alsaqr_pwr_seq.md
Name: pad_alsaqr_pwr_seq

Overview:
- Sequences power-up, power-down and retention for one bank of NUM_PADS pad_alsaqr cells.
- Drives the shared bank rails IOPWROK, PWROK and RETC with programmed inter-step delays.
- Forces pad control (OEN/I/PUEN) to a safe state during transitions and freezes it during retention.
- Sits between the core pad-mux outputs and the pad ring.

Parameters:
NUM_PADS, 32, pads in the bank
T_IO_CYC, 16, cycles from IOPWROK rise to PWROK rise; must be >=1
T_CORE_CYC, 16, cycles PWROK is held before ACTIVE, also PWR_DOWN and RET_EXIT duration; must be >=1
T_RET_CYC, 8, cycles from RETC rise to RETENTION; must be >=1
SAFE_PUEN, 1'b0, PUEN value driven while pads are forced safe

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
pwr_en_i  in  1  level request: bank powered
ret_req_i  in  1  level request: enter/hold retention
core_oen_i  in  NUM_PADS  core output-enable (active-low)
core_i_i  in  NUM_PADS  core output data
core_puen_i  in  NUM_PADS  core pull config
pad_oen_o  out  NUM_PADS  to pad OEN
pad_i_o  out  NUM_PADS  to pad I
pad_puen_o  out  NUM_PADS  to pad PUEN
iopwrok_o  out  1  to pad IOPWROK
pwrok_o  out  1  to pad PWROK
retc_o  out  1  to pad RETC
ready_o  out  1  bank usable by core
ret_ack_o  out  1  retention reached
state_o  out  3  current FSM state (debug)

Behaviour:
- All outputs registered. Reset is asynchronous; applying it at any point forces: state OFF, iopwrok/pwrok/retc/ready/ret_ack=0, pad_oen_o all 1, pad_i_o all 0, pad_puen_o all SAFE_PUEN.
- Delay timer: on each state entry that names a delay T, counter loads T-1. Counter decrements each cycle. The state exits in the cycle the counter is 0, so each timed state lasts exactly T cycles. Counter width is $clog2(max(T_*)+1).
- OFF: pads safe, all rails 0. pwr_en_i=1 -> IO_UP; iopwrok_o=1 in the next cycle.
- IO_UP (T_IO_CYC): pads safe. On expiry -> CORE_UP, pwrok_o=1.
- CORE_UP (T_CORE_CYC): pads safe. On expiry -> ACTIVE, ready_o=1.
- ACTIVE: pad_*_o <= core_*_i every cycle (1-cycle latency).
  - pwr_en_i=0 -> PWR_DOWN (highest priority).
  - Otherwise ret_req_i=1 -> RET_ENTER.
- RET_ENTER (T_RET_CYC): retc_o=1, ready_o=0. Pad registers stop updating and hold the last ACTIVE values. On expiry -> RETENTION, ret_ack_o=1, pwrok_o=0.
- RETENTION: pads frozen, retc_o=1, iopwrok_o=1.
  - pwr_en_i=0 -> PWR_DOWN.
  - Otherwise ret_req_i=0 -> RET_EXIT: ret_ack_o=0, pwrok_o=1.
- RET_EXIT (T_CORE_CYC): pads still frozen, retc_o=1. On expiry -> ACTIVE: retc_o=0, ready_o=1, pad tracking resumes the following cycle.
- PWR_DOWN (T_CORE_CYC): on entry, pads forced safe, pwrok_o=0, retc_o=0, ready_o=0, ret_ack_o=0. On expiry -> OFF, iopwrok_o=0.
- pwr_en_i=0 while in IO_UP, CORE_UP, RET_ENTER or RET_EXIT -> PWR_DOWN immediately; the timer is reloaded.
- ret_req_i is ignored outside ACTIVE and RETENTION. A ret_req_i drop during RET_ENTER completes entry, then exits via RETENTION the next cycle.
- pwr_en_i toggled during PWR_DOWN is ignored until OFF.
- Invariants: pwrok_o=1 implies iopwrok_o=1; ready_o=1 implies retc_o=0; pads are never driven from core inputs outside ACTIVE.

Decomposition:
- pad_alsaqr_pkg holds: the state enum (OFF, IO_UP, CORE_UP, ACTIVE, RET_ENTER, RETENTION, RET_EXIT, PWR_DOWN; 3-bit encoding matching state_o), safe-value constants SAFE_OEN=1 and SAFE_I=0, and a pad_ctrl_t struct {oen, i, puen}.
- One sub-module, pad_seq_timer (load value, load strobe, zero flag), is instantiated once.

Test Plan:
- Reset, then pwr_en_i=1 at cycle 0 with defaults -> iopwrok_o=1 at cycle 1, pwrok_o=1 at 17, ready_o=1 at 33; pads safe until 33, then core_i_i=0xA5A5A5A5 appears on pad_i_o one cycle later.
- ACTIVE with core_i_i=0x12345678, ret_req_i=1 -> retc_o=1 next cycle; ret_ack_o=1 and pwrok_o=0 8 cycles later; change core_i_i to 0xFFFFFFFF -> pad_i_o stays 0x12345678.
- From RETENTION, drop ret_req_i -> pwrok_o=1 next cycle; 16 cycles later ready_o=1, retc_o=0; pad_i_o follows core_i_i after one more cycle.
- pwr_en_i=0 during CORE_UP, 5 cycles after pwrok rise -> pwrok_o=0 and pads safe next cycle; iopwrok_o=0 16 cycles later; state OFF.
- pwr_en_i=0 and ret_req_i=1 in the same ACTIVE cycle -> PWR_DOWN taken, retc_o never rises.
- rst_ni low asynchronously mid RET_EXIT -> all outputs at reset values before the next clock edge; resequencing from OFF works normally.
